imem_loader: RTL and testbench
==============================

# imem_loader

Sequential writer that fills the CPU's 16-bit instruction memory from an 8-bit byte stream before execution starts. It pairs bytes big-endian into instruction words and writes them through the instruction memory write port at consecutive addresses from 0. It stops on the halt word 16'hFFFF, which is also written. While loading, it holds the CPU (PC and register writes) in reset, and releases it only after a clean load.

## Interface
- ADDR_W, 8: instruction memory address width; depth = 2**ADDR_W words
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load from IDLE or DONE, ignored otherwise
- in_valid  in  1  byte-stream valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  write data
- busy  out  1  load in progress
- done  out  1  load finished (clean or error)
- overflow  out  1  memory filled without seeing 16'hFFFF
- chk_err  out  1  checksum mismatch; constant 0 when checksum is compiled out
- word_count  out  ADDR_W+1  words written in the current load
- cpu_hold  out  1  holds the CPU in reset; equals ~(done && !overflow && !chk_err)

## Operation
- States: IDLE, HI, LO, WR, CHK, DONE.
- Reset values: state=IDLE, word_count=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, overflow=0, chk_err=0, cpu_hold=1, in_ready=0.
- IDLE or DONE, start=1 -> HI. Clears word_count, overflow, chk_err, done, and the checksum accumulator.
- HI: in_ready=1. On transfer, latch in_data into word[15:8], then -> LO.
- LO: in_ready=1. On transfer, latch in_data into word[7:0], then -> WR.
- WR: imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=word. On the next edge, word_count increments. Next state:
  - word==16'hFFFF -> CHK (checksum compiled in) or DONE (compiled out).
  - else word_count==2**ADDR_W-1 -> set overflow, go to DONE.
  - else -> HI.
- CHK: in_ready=1. On transfer, compare in_data with the accumulator. Set chk_err if they differ, then -> DONE.
- DONE: done=1, busy=0. Holds until start or rst.
- busy=1 in HI, LO, WR, CHK.
- in_ready=0 in IDLE, WR, DONE. Bytes offered then are not consumed.
- word_count saturates by construction; its maximum is 2**ADDR_W.
- start while busy is ignored.
- rst mid-load aborts immediately to the reset values. Words already written are not erased.

## Timing
- Minimum 3 cycles per word (HI, LO, WR) with in_valid held high.
- in_valid stalls extend HI/LO/CHK indefinitely.
- Write occurs the cycle after the low byte's transfer edge.
- done and cpu_hold update on the edge that enters DONE. The CPU first fetches address 0 on the following edge.
- With the terminator as word N (1-based) and no stalls, done rises 3N+1 cycles after the start edge; add one cycle with checksum.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - 8-bit XOR accumulator over every data byte, terminator bytes included.
  - After the terminator write, the CHK state consumes one checksum byte.
  - A mismatch sets chk_err, so cpu_hold stays 1.
- Undefined: CHK state is absent, WR goes directly to DONE on the terminator, and chk_err is tied 0.

## Structure
- Shared package `cpu_pkg`:
  - HALT_WORD = 16'hFFFF (shared with CPU halt detection).
  - INSTR_W = 16.
  - Loader state enum typedef.
- Single module, no sub-modules. The checksum accumulator is an inline register under the macro.

## Test plan
- Bytes 12 34 56 78 FF FF, in_valid always 1, checksum off -> writes 0:1234, 1:5678, 2:FFFF; word_count=3; done at cycle 10 after start; cpu_hold=0.
- Same stream with in_valid deasserted 2 cycles between each byte -> identical writes, no extra imem_we pulses, in_ready 0 only in WR.
- ADDR_W=2, stream of words 0001 0002 0003 0004 with no FFFF -> 4 writes, overflow=1, cpu_hold=1; a 5th byte is not accepted.
- rst asserted in LO during word 1 -> next cycle all outputs at reset values; start then reloads from address 0.
- Checksum on: 12 34 FF FF 26 -> chk_err=0, cpu_hold=0. Checksum byte 27 -> chk_err=1, cpu_hold=1.
- start pulsed in HI mid-load -> ignored, word_count unchanged; start in DONE -> counters cleared, new load begins.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, halt word and the loader state encoding.
package cpu_pkg;

  localparam int          INSTR_W   = 16;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Fills instruction memory from a big-endian byte stream, stopping at HALT_WORD.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               chk_err,
  output logic [ADDR_W:0]    word_count,
  output logic               cpu_hold
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  loader_state_t      state_reg;
  logic [INSTR_W-1:0] word_reg;
  logic [ADDR_W:0]    word_count_reg;
  logic               overflow_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         acc_reg;
  logic               chk_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      word_reg       <= '0;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_reg        <= '0;
      chk_err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg      <= ST_HI;
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_reg        <= '0;
            chk_err_reg    <= 1'b0;
`endif
          end
        end
        ST_HI: begin
          if (in_valid) begin
            word_reg[15:8] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_reg        <= acc_reg ^ in_data;
`endif
            state_reg      <= ST_LO;
          end
        end
        ST_LO: begin
          if (in_valid) begin
            word_reg[7:0] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_reg       <= acc_reg ^ in_data;
`endif
            state_reg     <= ST_WR;
          end
        end
        ST_WR: begin
          // The halt word takes priority, so a terminator in the last slot is a clean load.
          word_count_reg <= word_count_reg + 1'b1;
          if (word_reg == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_reg <= ST_CHK;
`else
            state_reg <= ST_DONE;
`endif
          end else if (word_count_reg == LAST_IDX) begin
            overflow_reg <= 1'b1;
            state_reg    <= ST_DONE;
          end else begin
            state_reg <= ST_HI;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (in_valid) begin
            chk_err_reg <= (in_data != acc_reg);
            state_reg   <= ST_DONE;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == ST_HI) || (state_reg == ST_LO) || (state_reg == ST_CHK);
  assign imem_we    = (state_reg == ST_WR);
  assign imem_addr  = word_count_reg[ADDR_W-1:0];
  assign imem_wdata = word_reg;
  assign busy       = (state_reg == ST_HI) || (state_reg == ST_LO) ||
                      (state_reg == ST_WR) || (state_reg == ST_CHK);
  assign done       = (state_reg == ST_DONE);
  assign overflow   = overflow_reg;
  assign word_count = word_count_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_err    = chk_err_reg;
`else
  assign chk_err    = 1'b0;
`endif
  assign cpu_hold   = ~(done && !overflow && !chk_err);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory (ADDR_W=2); the
// checksum cases run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              chk_err;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .chk_err    (chk_err),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          wr_cnt   = 0;
  int          viol     = 0;
  int          done_at  = 0;
  logic        done_d   = 1'b0;
  logic [15:0] mem_model [4];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_we) begin
      mem_model[imem_addr] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // While busy, the loader refuses bytes exactly in its write cycle.
  always @(negedge clk) begin
    done_d <= done;
    if (done && !done_d) done_at <= cyc;
    if (busy && (in_ready == imem_we)) viol <= viol + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_std(input int gap);
    logic [7:0] s [6];
    s = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) send_byte(s[i], gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h08, gap);
`endif
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int t0;
  int w0;
  int exp_cyc;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cpu_hold", cpu_hold, 1);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_imem_we", imem_we, 0);
    check_eq("rst_word_count", word_count, 0);

    // Basic load, in_valid held high
    w0 = wr_cnt;
    pulse_start();
    t0 = cyc;
    load_std(0);
    check_eq("basic_w0", mem_model[0], 16'h1234);
    check_eq("basic_w1", mem_model[1], 16'h5678);
    check_eq("basic_w2", mem_model[2], 16'hFFFF);
    check_eq("basic_nwr", wr_cnt - w0, 3);
    check_eq("basic_word_count", word_count, 3);
    check_eq("basic_done", done, 1);
    check_eq("basic_cpu_hold", cpu_hold, 0);
    check_eq("basic_overflow", overflow, 0);
    check_eq("basic_chk_err", chk_err, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_cyc = 11;
`else
    exp_cyc = 10;
`endif
    check_eq("basic_done_cycle", done_at - t0 + 1, exp_cyc);
    check_eq("basic_ready_rule", viol, 0);

    // Same stream with two idle cycles between bytes
    w0 = wr_cnt;
    pulse_start();
    check_eq("restart_done_clr", done, 0);
    check_eq("restart_wc_clr", word_count, 0);
    load_std(2);
    check_eq("stall_w0", mem_model[0], 16'h1234);
    check_eq("stall_w1", mem_model[1], 16'h5678);
    check_eq("stall_w2", mem_model[2], 16'hFFFF);
    check_eq("stall_nwr", wr_cnt - w0, 3);
    check_eq("stall_ready_rule", viol, 0);
    check_eq("stall_cpu_hold", cpu_hold, 0);

    // Fill all 4 words without a terminator
    w0 = wr_cnt;
    pulse_start();
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'h00, 0);
      send_byte(8'(i), 0);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("ovf_nwr", wr_cnt - w0, 4);
    check_eq("ovf_w3", mem_model[3], 16'h0004);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_done", done, 1);
    check_eq("ovf_cpu_hold", cpu_hold, 1);
    check_eq("ovf_word_count", word_count, 4);
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ovf_no_accept", in_ready, 0);
    end
    in_valid = 1'b0;
    check_eq("ovf_no_extra_wr", wr_cnt - w0, 4);

    // Reset while waiting for the low byte of word 1
    pulse_start();
    send_byte(8'hAB, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_overflow", overflow, 0);
    check_eq("abort_cpu_hold", cpu_hold, 1);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_imem_addr", imem_addr, 0);
    check_eq("abort_imem_wdata", imem_wdata, 0);
    check_eq("abort_word_count", word_count, 0);
    w0 = wr_cnt;
    pulse_start();
    load_std(0);
    check_eq("reload_w0", mem_model[0], 16'h1234);
    check_eq("reload_nwr", wr_cnt - w0, 3);
    check_eq("reload_cpu_hold", cpu_hold, 0);

    // start mid-load is ignored
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("midstart_wc_before", word_count, 1);
    pulse_start();
    check_eq("midstart_wc", word_count, 1);
    check_eq("midstart_busy", busy, 1);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h33, 0);
`endif
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midstart_w0", mem_model[0], 16'h1122);
    check_eq("midstart_w1", mem_model[1], 16'hFFFF);
    check_eq("midstart_done", done, 1);
    check_eq("midstart_word_count", word_count, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good then bad
    pulse_start();
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h26, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("cs_good_chk_err", chk_err, 0);
    check_eq("cs_good_cpu_hold", cpu_hold, 0);
    pulse_start();
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h27, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("cs_bad_chk_err", chk_err, 1);
    check_eq("cs_bad_cpu_hold", cpu_hold, 1);
    check_eq("cs_bad_done", done, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: a hung bench still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
